// File: rtl/oup_sm_ulpi_syncmode_rx.sv
// Link-side ULPI synchronous-mode receive machine: tracks dir/turnarounds and splits PHY traffic
// into USB bytes, RX CMD status and register-read data. Option macro: OUP_ULPI_RXCMD_FILTER_EN.
//
// state     | meaning (role of the bus cycle sampled at the last edge)
// IDLE      | link owns the bus, dir low
// TURN_IN   | dir rose (or a register read was pre-empted), data ignored
// RX        | PHY cycle carrying a USB byte (nxt=1) or an RX CMD (nxt=0)
// REGR_TURN | dir rose with a register read pending and nxt low, data ignored
// REGR_DATA | register-read data captured into phyreg_o
// TURN_OUT  | dir fell, data ignored
module oup_sm_ulpi_syncmode_rx #(
    parameter int REGR_TIMEOUT = 15
) (
    input  logic       ulpi_clk_i,
    input  logic       rst_i,
    input  logic [7:0] ulpi_data_i,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    output logic [7:0] rx_data_o,
    output logic       rx_data_valid_o,
    input  logic       rx_fifo_full_i,
    output logic       rx_overflow_o,
    output logic       rx_packet_end_o,
    output logic [7:0] rxcmd_o,
    output logic       rxcmd_valid_o,
    output logic       rx_active_o,
    output logic       rx_error_o,
    output logic [7:0] phyreg_o,
    input  logic       rx_regr_assert_i,
    output logic       rx_done_o,
    output logic       rx_abort_o
);

    typedef enum logic [2:0] {
        IDLE,
        TURN_IN,
        RX,
        REGR_TURN,
        REGR_DATA,
        TURN_OUT
    } state_t;

    localparam logic [7:0] TMR_TC = 8'(REGR_TIMEOUT - 1);

    state_t     state;
    logic [7:0] tmr_cnt;
    logic       regr_pending;
    logic       rxcmd_active;
    logic       rxcmd_error;
    logic       rxcmd_strobe;

    assign regr_pending = rx_regr_assert_i & ~rx_done_o & ~rx_abort_o;
    // RxEvent 01 and 11 both mean RxActive, so bit 4 alone decides activity
    assign rxcmd_active = ulpi_data_i[4];
    assign rxcmd_error  = ulpi_data_i[5] & ulpi_data_i[4];

`ifdef OUP_ULPI_RXCMD_FILTER_EN
    assign rxcmd_strobe = (ulpi_data_i != rxcmd_o);
`else
    assign rxcmd_strobe = 1'b1;
`endif

    always_ff @(posedge ulpi_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            tmr_cnt         <= 8'd0;
            rx_data_o       <= 8'd0;
            rx_data_valid_o <= 1'b0;
            rx_overflow_o   <= 1'b0;
            rx_packet_end_o <= 1'b0;
            rxcmd_o         <= 8'd0;
            rxcmd_valid_o   <= 1'b0;
            rx_active_o     <= 1'b0;
            rx_error_o      <= 1'b0;
            phyreg_o        <= 8'd0;
            rx_done_o       <= 1'b0;
            rx_abort_o      <= 1'b0;
        end else begin
            rx_data_valid_o <= 1'b0;
            rx_packet_end_o <= 1'b0;
            rxcmd_valid_o   <= 1'b0;

            case (state)
                IDLE, TURN_OUT: begin
                    if (ulpi_dir_i) begin
                        if (regr_pending && !ulpi_nxt_i) begin
                            state <= REGR_TURN;
                        end else begin
                            state <= TURN_IN;
                            if (regr_pending) begin
                                rx_abort_o <= 1'b1;
                            end
                            if (ulpi_nxt_i && !rx_active_o) begin
                                rx_active_o   <= 1'b1;
                                rx_error_o    <= 1'b0;
                                rx_overflow_o <= 1'b0;
                            end
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                TURN_IN, RX, REGR_DATA: begin
                    if (ulpi_dir_i) begin
                        state <= RX;
                        if (ulpi_nxt_i) begin
                            if (rx_fifo_full_i) begin
                                rx_overflow_o <= 1'b1;
                            end else begin
                                rx_data_o       <= ulpi_data_i;
                                rx_data_valid_o <= 1'b1;
                            end
                        end else begin
                            rxcmd_o       <= ulpi_data_i;
                            rxcmd_valid_o <= rxcmd_strobe;
                            if (rxcmd_active && !rx_active_o) begin
                                rx_active_o   <= 1'b1;
                                rx_error_o    <= 1'b0;
                                rx_overflow_o <= 1'b0;
                            end else if (!rxcmd_active && rx_active_o) begin
                                rx_active_o     <= 1'b0;
                                rx_packet_end_o <= 1'b1;
                            end
                            if (rxcmd_error) begin
                                rx_error_o <= 1'b1;
                            end
                        end
                    end else begin
                        state <= TURN_OUT;
                        if (rx_active_o) begin
                            rx_active_o     <= 1'b0;
                            rx_packet_end_o <= 1'b1;
                        end
                    end
                end

                REGR_TURN: begin
                    if (ulpi_dir_i) begin
                        if (ulpi_nxt_i) begin
                            // PHY pre-empted the read with a USB receive: treat as RX start
                            state <= TURN_IN;
                            if (regr_pending) begin
                                rx_abort_o <= 1'b1;
                            end
                            if (!rx_active_o) begin
                                rx_active_o   <= 1'b1;
                                rx_error_o    <= 1'b0;
                                rx_overflow_o <= 1'b0;
                            end
                        end else begin
                            state    <= REGR_DATA;
                            phyreg_o <= ulpi_data_i;
                            if (regr_pending) begin
                                rx_done_o <= 1'b1;
                            end
                        end
                    end else begin
                        state <= TURN_OUT;
                        if (rx_active_o) begin
                            rx_active_o     <= 1'b0;
                            rx_packet_end_o <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // done/abort are levels owned by the request; dropping it releases them
            if (!rx_regr_assert_i) begin
                tmr_cnt    <= 8'd0;
                rx_done_o  <= 1'b0;
                rx_abort_o <= 1'b0;
            end else if (!ulpi_dir_i && !rx_done_o && !rx_abort_o) begin
                if (tmr_cnt == TMR_TC) begin
                    rx_abort_o <= 1'b1;
                end else begin
                    tmr_cnt <= tmr_cnt + 8'd1;
                end
            end
        end
    end

endmodule
